// File: rtl/uart_pkg.sv
// Shared types for the UART result path: serializer state encoding and
// word-to-byte sizing helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      SEND,
      GUARD,
      WAITTX,
      DONE
   } tx_ser_state_t;

   function automatic int bytes_per_word(input int width, input int uart_width);
      return (width + uart_width - 1) / uart_width;
   endfunction

endpackage

// File: rtl/dmem_tx_serializer_if.sv
// Data-memory read port and UART transmitter handshake seen by the serializer.
interface dmem_tx_serializer_if #(
   parameter int ADDR_WIDTH      = 12,
   parameter int MEM_WORD_LENGTH = 48,
   parameter int UART_WIDTH      = 8
);
   logic [ADDR_WIDTH-1:0]      mem_address;
   logic [MEM_WORD_LENGTH-1:0] dataFromMem;
   logic                       txByteReady;
   logic                       txByteStart;
   logic [UART_WIDTH-1:0]      byteForTx;

   modport master (
      output mem_address, txByteStart, byteForTx,
      input  dataFromMem, txByteReady
   );

   modport slave (
      input  mem_address, txByteStart, byteForTx,
      output dataFromMem, txByteReady
   );
endinterface

// File: rtl/dmem_tx_serializer.sv
// Streams an inclusive range of data-memory words to the UART, LSB byte first,
// and holds done once the last byte has left and the UART is ready again.
//
// state   | meaning
// IDLE    | waiting for txStartN low
// FETCH   | RAM samples mem_address
// CAPTURE | load read word into shift register, clear byte counter
// SEND    | present low byte, pulse txByteStart when UART ready
// GUARD   | ignore ready for one cycle while the UART drops it
// WAITTX  | wait for UART ready, then next byte / next word / finish
// DONE    | range complete, done held until restart or reset
module dmem_tx_serializer
   import uart_pkg::*;
#(
   parameter  int MEM_WORD_LENGTH = 48,
   parameter  int MEM_DEPTH       = 4096,
   parameter  int UART_WIDTH      = 8,
   localparam int ADDR_WIDTH      = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  txStartN,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH-1:0] end_addr,
   dmem_tx_serializer_if.master  bus,
   output logic                  busy,
   output logic                  done
);

   localparam int NB = bytes_per_word(MEM_WORD_LENGTH, UART_WIDTH);
   localparam int SW = NB * UART_WIDTH;
   localparam int CW = $clog2(NB + 1);
   localparam logic [CW-1:0] NB_C = CW'(NB);

   tx_ser_state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] end_q;
   logic [SW-1:0]         shift_q;
   logic [CW-1:0]         cnt_q;

   logic start_hit;
   logic range_empty;
   logic send_hit;
   logic word_done;
   logic last_word;

   assign range_empty = end_addr < start_addr;
   assign start_hit   = (state == IDLE || state == DONE) && !txStartN;
   assign send_hit    = (state == SEND) && bus.txByteReady;
   assign word_done   = cnt_q >= NB_C;
   assign last_word   = addr_q == end_q;

   always_ff @(posedge clk) begin
      if (!rstN) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, DONE: if (!txStartN) state_nxt = range_empty ? DONE : FETCH;
         FETCH:      state_nxt = CAPTURE;
         CAPTURE:    state_nxt = SEND;
         SEND:       if (bus.txByteReady) state_nxt = GUARD;
         GUARD:      state_nxt = WAITTX;
         WAITTX: begin
            if (bus.txByteReady) begin
               if (!word_done)     state_nxt = SEND;
               else if (last_word) state_nxt = DONE;
               else                state_nxt = FETCH;
            end
         end
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         addr_q  <= '0;
         end_q   <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         if (start_hit && !range_empty) begin
            addr_q <= start_addr;
            end_q  <= end_addr;
         end
         if (state == CAPTURE) begin
            shift_q <= SW'(bus.dataFromMem);
            cnt_q   <= '0;
         end
         if (send_hit) begin
            shift_q <= shift_q >> UART_WIDTH;
            cnt_q   <= cnt_q + 1'b1;
         end
         // address only advances while below the latched end, so it never wraps
         if (state == WAITTX && bus.txByteReady && word_done && !last_word)
            addr_q <= addr_q + 1'b1;
      end
   end

   assign bus.mem_address = addr_q;
   assign bus.byteForTx   = shift_q[UART_WIDTH-1:0];
   // gated by rstN so a reset cycle landing in SEND never emits a request
   assign bus.txByteStart = send_hit && rstN;
   assign busy            = (state != IDLE) && (state != DONE);
   assign done            = state == DONE;

endmodule

// File: tb/tb_dmem_tx_serializer.sv
// Bench for dmem_tx_serializer: RAM and UART models, byte stream compared
// against words unpacked arithmetically from the memory image.
module tb_dmem_tx_serializer;
   import uart_pkg::*;

   localparam int W   = 48;
   localparam int D   = 4096;
   localparam int AW  = 12;
   localparam int NB  = 6;
   localparam int W2  = 12;
   localparam int D2  = 16;
   localparam int AW2 = 4;
   localparam int NB2 = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rstN = 1'b0;
   logic           txStartN = 1'b1;
   logic           txStartN2 = 1'b1;
   logic [AW-1:0]  start_addr = '0, end_addr = '0;
   logic [AW2-1:0] start_addr2 = '0, end_addr2 = '0;
   logic           busy, done, busy2, done2;

   dmem_tx_serializer_if #(.ADDR_WIDTH(AW),  .MEM_WORD_LENGTH(W),  .UART_WIDTH(8)) bus ();
   dmem_tx_serializer_if #(.ADDR_WIDTH(AW2), .MEM_WORD_LENGTH(W2), .UART_WIDTH(8)) bus2 ();

   dmem_tx_serializer #(.MEM_WORD_LENGTH(W), .MEM_DEPTH(D), .UART_WIDTH(8)) dut (
      .clk(clk), .rstN(rstN), .txStartN(txStartN),
      .start_addr(start_addr), .end_addr(end_addr),
      .bus(bus.master), .busy(busy), .done(done)
   );

   dmem_tx_serializer #(.MEM_WORD_LENGTH(W2), .MEM_DEPTH(D2), .UART_WIDTH(8)) dut2 (
      .clk(clk), .rstN(rstN), .txStartN(txStartN2),
      .start_addr(start_addr2), .end_addr(end_addr2),
      .bus(bus2.master), .busy(busy2), .done(done2)
   );

   int tests = 0;
   int fails = 0;

   logic [W-1:0]  mem  [D];
   logic [W2-1:0] mem2 [D2];
   always @(posedge clk) bus.dataFromMem  <= mem[bus.mem_address];
   always @(posedge clk) bus2.dataFromMem <= mem2[bus2.mem_address];

   // UART model: ready drops on the accepting edge and returns after bt edges
   int bt = 10, ucnt = 0, dbl_viol = 0, nrdy_viol = 0;
   bit hold_low = 1'b0, prev_start = 1'b0;
   logic [7:0]    got [$];
   logic [AW-1:0] addr_log [$];
   always @(posedge clk) begin
      if (bus.txByteStart === 1'b1) begin
         if (bus.txByteReady !== 1'b1) nrdy_viol++;
         if (prev_start) dbl_viol++;
         got.push_back(bus.byteForTx);
         ucnt = bt;
      end else if (ucnt > 0) begin
         ucnt--;
      end
      prev_start = (bus.txByteStart === 1'b1);
      bus.txByteReady <= (ucnt == 0) && !hold_low;
      if (busy === 1'b1 && (addr_log.size() == 0 || addr_log[addr_log.size()-1] != bus.mem_address))
         addr_log.push_back(bus.mem_address);
   end

   int ucnt2 = 0;
   logic [7:0] got2 [$];
   always @(posedge clk) begin
      if (bus2.txByteStart === 1'b1) begin
         if (bus2.txByteReady !== 1'b1) nrdy_viol++;
         got2.push_back(bus2.byteForTx);
         ucnt2 = 3;
      end else if (ucnt2 > 0) begin
         ucnt2--;
      end
      bus2.txByteReady <= (ucnt2 == 0);
   end

   logic [7:0] exp [$];

   function automatic void push_words(input int s, input int e);
      for (int a = s; a <= e; a++)
         for (int b = 0; b < NB; b++)
            exp.push_back(8'(mem[a] >> (8 * b)));
   endfunction

   function automatic void push_words2(input int s, input int e);
      for (int a = s; a <= e; a++)
         for (int b = 0; b < NB2; b++)
            exp.push_back(8'(mem2[a] >> (8 * b)));
   endfunction

   // index of first difference between captured and expected stream, -1 if equal
   function automatic int first_diff(input bit sel);
      int n;
      n = sel ? got2.size() : got.size();
      if (n != exp.size()) return (n < exp.size()) ? n : exp.size();
      for (int i = 0; i < n; i++)
         if ((sel ? got2[i] : got[i]) !== exp[i]) return i;
      return -1;
   endfunction

   task automatic kick(input logic [AW-1:0] s, input logic [AW-1:0] e);
      @(negedge clk);
      start_addr = s;
      end_addr   = e;
      txStartN   = 1'b0;
      @(posedge clk);
      #1 txStartN = 1'b1;
   endtask

   task automatic kick2(input logic [AW2-1:0] s, input logic [AW2-1:0] e);
      @(negedge clk);
      start_addr2 = s;
      end_addr2   = e;
      txStartN2   = 1'b0;
      @(posedge clk);
      #1 txStartN2 = 1'b1;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_done2(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done2 === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset;
      rstN = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
      tests++; if (bus.txByteStart !== 1'b0) begin fails++; $display("FAIL reset_start got %b want 0", bus.txByteStart); end
      tests++; if (bus.byteForTx !== 8'h00) begin fails++; $display("FAIL reset_byte got %h want 00", bus.byteForTx); end
      tests++; if (bus.mem_address !== '0) begin fails++; $display("FAIL reset_addr got %0d want 0", bus.mem_address); end
      tests++; if (busy2 !== 1'b0 || done2 !== 1'b0) begin fails++; $display("FAIL reset_inst2 got busy=%b done=%b want 0 0", busy2, done2); end
      rstN = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_word;
      int lat;
      bit ok;
      int d;
      mem[5] = 48'h0605_0403_0201;
      bt = 10;
      got.delete(); addr_log.delete(); exp.delete();
      push_words(5, 5);
      kick(12'd5, 12'd5);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.txByteStart === 1'b1) begin lat = k; break; end
      end
      tests++; if (lat != 3) begin fails++; $display("FAIL first_latency got %0d want 3", lat); end
      wait_done(2000, ok);
      tests++; if (!ok) begin fails++; $display("FAIL single_done_timeout got 0 want 1"); end
      d = first_diff(1'b0);
      tests++; if (d != -1) begin fails++; $display("FAIL single_bytes idx %0d got_n %0d want_n %0d", d, got.size(), exp.size()); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy got %b want 0", busy); end
      tests++; if (addr_log.size() != 1 || addr_log[0] != 12'd5) begin fails++; $display("FAIL single_addr got n=%0d want 1 entry of 5", addr_log.size()); end
   endtask

   task automatic test_multi_word;
      bit ok;
      int d;
      for (int a = 2; a <= 4; a++) mem[a] = W'({$urandom(), $urandom()}) ^ W'(a);
      bt = $urandom_range(1, 6);
      got.delete(); addr_log.delete(); exp.delete();
      push_words(2, 4);
      kick(12'd2, 12'd4);
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL restart_clears_done got %b want 0", done); end
      wait_done(3000, ok);
      tests++; if (!ok) begin fails++; $display("FAIL multi_done_timeout got 0 want 1"); end
      d = first_diff(1'b0);
      tests++; if (d != -1) begin fails++; $display("FAIL multi_bytes idx %0d got_n %0d want_n 18", d, got.size()); end
      tests++;
      if (addr_log.size() != 3 || addr_log[0] != 12'd2 || addr_log[1] != 12'd3 || addr_log[2] != 12'd4) begin
         fails++; $display("FAIL multi_addr_seq got n=%0d want 2,3,4", addr_log.size());
      end
   endtask

   task automatic test_reverse_range;
      got.delete();
      kick(12'd3, 12'd1);
      tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL reverse_done got done=%b busy=%b want 1 0", done, busy); end
      repeat (20) @(negedge clk);
      tests++; if (got.size() != 0) begin fails++; $display("FAIL reverse_no_bytes got %0d want 0", got.size()); end
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL done_level got %b want 1", done); end
   endtask

   task automatic test_top_addr;
      bit ok;
      int d;
      bt = 2;
      got.delete(); addr_log.delete(); exp.delete();
      push_words(D - 2, D - 1);
      kick(12'(D - 2), 12'(D - 1));
      wait_done(2000, ok);
      tests++; if (!ok) begin fails++; $display("FAIL top_done_timeout got 0 want 1"); end
      d = first_diff(1'b0);
      tests++; if (d != -1) begin fails++; $display("FAIL top_bytes idx %0d got_n %0d want_n %0d", d, got.size(), exp.size()); end
      tests++;
      if (addr_log.size() != 2 || addr_log[1] != 12'(D - 1)) begin
         fails++; $display("FAIL top_addr got n=%0d want 4094,4095", addr_log.size());
      end
      repeat (5) @(negedge clk);
      tests++; if (bus.mem_address !== 12'(D - 1)) begin fails++; $display("FAIL top_no_wrap got %0d want %0d", bus.mem_address, D - 1); end
   endtask

   task automatic test_ready_stall;
      bit ok;
      int d;
      bt = 3;
      hold_low = 1'b1;
      repeat (3) @(negedge clk);
      got.delete(); addr_log.delete(); exp.delete();
      push_words(20, 21);
      kick(12'd20, 12'd21);
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (c == 10) begin start_addr = 12'd0; end_addr = 12'd0; txStartN = 1'b0; end
         if (c == 11) txStartN = 1'b1;
         if (c == 12) begin start_addr = 12'd7; end_addr = 12'd9; end
      end
      tests++; if (got.size() != 0) begin fails++; $display("FAIL stall_no_pulse got %0d want 0", got.size()); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL stall_busy got %b want 1", busy); end
      hold_low = 1'b0;
      wait_done(2000, ok);
      tests++; if (!ok) begin fails++; $display("FAIL stall_done_timeout got 0 want 1"); end
      d = first_diff(1'b0);
      tests++; if (d != -1) begin fails++; $display("FAIL stall_bytes idx %0d got_n %0d want_n %0d", d, got.size(), exp.size()); end
      tests++;
      if (addr_log.size() != 2 || addr_log[0] != 12'd20) begin
         fails++; $display("FAIL busy_start_ignored got n=%0d want 20,21", addr_log.size());
      end
   endtask

   task automatic test_random;
      bit ok;
      int d, s, e, n_words;
      for (int it = 0; it < 8; it++) begin
         s = $urandom_range(1, 60);
         e = (it % 4 == 3) ? s - 1 : s + $urandom_range(0, 3);
         bt = $urandom_range(1, 8);
         for (int a = s; a <= e; a++) mem[a] = W'({$urandom(), $urandom()});
         got.delete(); addr_log.delete(); exp.delete();
         push_words(s, e);
         n_words = (e >= s) ? e - s + 1 : 0;
         kick(12'(s), 12'(e));
         wait_done(5000, ok);
         repeat (2) @(negedge clk);
         tests++; if (!ok) begin fails++; $display("FAIL rand%0d_timeout got 0 want 1", it); end
         d = first_diff(1'b0);
         tests++; if (d != -1) begin fails++; $display("FAIL rand%0d_bytes idx %0d got_n %0d want_n %0d", it, d, got.size(), exp.size()); end
         tests++; if (addr_log.size() != n_words) begin fails++; $display("FAIL rand%0d_words got %0d want %0d", it, addr_log.size(), n_words); end
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      int d;
      bt = 4;
      for (int a = 10; a <= 12; a++) mem[a] = W'({$urandom(), $urandom()});
      got.delete();
      kick(12'd10, 12'd12);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (got.size() >= NB + 2) begin ok = 1'b1; break; end
      end
      tests++; if (!ok) begin fails++; $display("FAIL midreset_reach_timeout got %0d bytes want %0d", got.size(), NB + 2); end
      rstN = 1'b0;
      @(negedge clk);
      tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midreset_state got busy=%b done=%b want 0 0", busy, done); end
      tests++; if (bus.txByteStart !== 1'b0) begin fails++; $display("FAIL midreset_start got %b want 0", bus.txByteStart); end
      tests++; if (bus.byteForTx !== 8'h00 || bus.mem_address !== '0) begin fails++; $display("FAIL midreset_outputs got byte=%h addr=%0d want 00 0", bus.byteForTx, bus.mem_address); end
      rstN = 1'b1;
      repeat (12) @(negedge clk);
      got.delete(); addr_log.delete(); exp.delete();
      push_words(10, 12);
      kick(12'd10, 12'd12);
      wait_done(3000, ok);
      tests++; if (!ok) begin fails++; $display("FAIL replay_timeout got 0 want 1"); end
      d = first_diff(1'b0);
      tests++; if (d != -1) begin fails++; $display("FAIL replay_bytes idx %0d got_n %0d want_n %0d", d, got.size(), exp.size()); end
      tests++; if (addr_log.size() != 3 || addr_log[0] != 12'd10) begin fails++; $display("FAIL replay_addr got n=%0d want 10,11,12", addr_log.size()); end
   endtask

   task automatic test_narrow_word;
      bit ok;
      int d;
      mem2[7] = 12'hABC;
      got2.delete(); exp.delete();
      exp.push_back(8'hBC);
      exp.push_back(8'h0A);
      kick2(4'd7, 4'd7);
      wait_done2(500, ok);
      tests++; if (!ok) begin fails++; $display("FAIL narrow_timeout got 0 want 1"); end
      d = first_diff(1'b1);
      tests++; if (d != -1) begin fails++; $display("FAIL narrow_bytes idx %0d got_n %0d want BC,0A", d, got2.size()); end
      mem2[14] = 12'($urandom());
      mem2[15] = 12'($urandom());
      got2.delete(); exp.delete();
      push_words2(14, 15);
      kick2(4'd14, 4'd15);
      wait_done2(500, ok);
      d = first_diff(1'b1);
      tests++; if (!ok || d != -1) begin fails++; $display("FAIL narrow_top ok=%b idx %0d got_n %0d want_n 4", ok, d, got2.size()); end
   endtask

   task automatic test_protocol;
      tests++; if (nrdy_viol != 0) begin fails++; $display("FAIL start_without_ready got %0d want 0", nrdy_viol); end
      tests++; if (dbl_viol != 0) begin fails++; $display("FAIL start_back_to_back got %0d want 0", dbl_viol); end
   endtask

   initial begin
      for (int i = 0; i < D; i++) mem[i] = W'({$urandom(), $urandom()});
      for (int i = 0; i < D2; i++) mem2[i] = 12'($urandom());
      test_reset();
      test_single_word();
      test_multi_word();
      test_reverse_range();
      test_top_addr();
      test_ready_stall();
      test_random();
      test_reset_mid();
      test_narrow_word();
      test_protocol();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
